// File: rtl/carrd_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// carrd_wb_arbiter_if
//   Bundles the writeback arbiter's requester handshake and its regfile write
//   port into one interface.
//
//   slave  : arbiter view. It takes unit results and the regfile stall, and it
//            drives ready, the write enables, the address and the data lanes.
//   master : the opposite view, used by the units and the regfile.
//
//   Signals
//     req_valid/req_ready  per-unit handshake (NREQ bits each)
//     req_dest             2 bits per unit: 0 none, 1 vreg, 2 xreg, 3 element
//     req_addr             AW bits per unit
//     req_data             DW bits per unit; unit i at [DW*i +: DW]
//     wr_stall             regfile cannot take a write this cycle
//     v/x/el_wr_en, wr_addr, reg_wr_data[_2.._4]   registered write port
//     wb_busy, wb_err      status
// ---------------------------------------------------------------------------
interface carrd_wb_arbiter_if #(
  parameter int NREQ = 5,
  parameter int DW   = 512,
  parameter int AW   = 5
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [2*NREQ-1:0]  req_dest;
  logic [AW*NREQ-1:0] req_addr;
  logic [DW*NREQ-1:0] req_data;
  logic               wr_stall;
  logic               v_reg_wr_en;
  logic               x_reg_wr_en;
  logic               el_wr_en;
  logic [AW-1:0]      wr_addr;
  logic [127:0]       reg_wr_data;
  logic [127:0]       reg_wr_data_2;
  logic [127:0]       reg_wr_data_3;
  logic [127:0]       reg_wr_data_4;
  logic               wb_busy;
  logic               wb_err;

  modport slave (
    input  req_valid, req_dest, req_addr, req_data, wr_stall,
    output req_ready, v_reg_wr_en, x_reg_wr_en, el_wr_en, wr_addr,
           reg_wr_data, reg_wr_data_2, reg_wr_data_3, reg_wr_data_4,
           wb_busy, wb_err
  );

  modport master (
    output req_valid, req_dest, req_addr, req_data, wr_stall,
    input  req_ready, v_reg_wr_en, x_reg_wr_en, el_wr_en, wr_addr,
           reg_wr_data, reg_wr_data_2, reg_wr_data_3, reg_wr_data_4,
           wb_busy, wb_err
  );
endinterface

// File: rtl/carrd_wb_arbiter.sv
// ---------------------------------------------------------------------------
// carrd_wb_arbiter
//   Shares the single vector/scalar register-file write port among the five
//   vector units (0 VALU, 1 VMUL, 2 VLSU, 3 VSLDU, 4 VRED). Each cycle one
//   valid unit is granted. Its result is captured into a registered write
//   stage, and that stage holds the write for as long as the regfile stalls.
//
//   Ports
//     clk   clock, rising edge
//     rst   asynchronous reset, active-high; any held write is discarded
//     bus   carrd_wb_arbiter_if.slave (handshake in, regfile write port out)
//
//   Configuration
//     CARRD_WB_RR_EN  defined   : round-robin arbitration from rr_ptr
//                     undefined : fixed priority, lowest index wins
// ---------------------------------------------------------------------------
module carrd_wb_arbiter #(
  parameter int NREQ = 5,
  parameter int DW   = 512,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  carrd_wb_arbiter_if.slave    bus
);

  localparam int IW = $clog2(NREQ);

  // ST_HOLD covers both WRITE and STALL. The two differ only in the current
  // wr_stall input: a stall holds the write, and a stall-free cycle commits it.
  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t          state, state_nxt;
  logic            out_valid;
  logic            accept_ok;
  logic            transfer;
  logic            found;
  logic [IW-1:0]   winner;
  logic [1:0]      win_dest;
  logic [1:0]      dest_eff;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  logic [1:0]      dest_p1;
  logic [AW-1:0]   addr_p1;
  logic [DW-1:0]   data_p1;
  logic            err_p1;

`ifdef CARRD_WB_RR_EN
  logic [IW-1:0]   rr_ptr;
`endif

  // ---- stage p0: arbitration over the unit requests -----------------------
`ifdef CARRD_WB_RR_EN
  always_comb begin
    int j;
    j      = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && bus.req_valid[j]) begin
        found  = 1'b1;
        winner = IW'(j);
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    found  = 1'b0;
    // Scanning downward leaves the lowest valid index as the winner.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) begin
        found  = 1'b1;
        winner = IW'(k);
      end
    end
  end
`endif

  always_comb begin
    win_dest = bus.req_dest[2*int'(winner) +: 2];
    win_addr = bus.req_addr[AW*int'(winner) +: AW];
    win_data = bus.req_data[DW*int'(winner) +: DW];
    // Only VRED may write a single element. From any other unit that
    // encoding is treated as "no destination".
    dest_eff = win_dest;
    if (win_dest == 2'd3 && winner != IW'(NREQ - 1)) dest_eff = 2'd0;
  end

  // ---- FSM: state register -------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // ---- FSM: next state -----------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (transfer)
      state_nxt = (dest_eff != 2'd0) ? ST_HOLD : ST_IDLE;
    else if (state == ST_HOLD && !bus.wr_stall)
      state_nxt = ST_IDLE;
  end

  // ---- FSM: outputs --------------------------------------------------------
  always_comb begin
    out_valid = (state == ST_HOLD);
    // A write that commits in this cycle frees the stage. A new winner can
    // therefore be accepted in the same cycle, which gives one write per cycle.
    accept_ok = !(out_valid && bus.wr_stall);
    transfer  = accept_ok && found;

    bus.req_ready = '0;
    if (transfer) bus.req_ready[winner] = 1'b1;

    bus.v_reg_wr_en = out_valid && (dest_p1 == 2'd1);
    bus.x_reg_wr_en = out_valid && (dest_p1 == 2'd2);
    bus.el_wr_en    = out_valid && (dest_p1 == 2'd3);
    bus.wb_busy     = out_valid;
    bus.wb_err      = err_p1;

    // The data registers are not reset. Gating them with out_valid keeps
    // the port at zero both out of reset and while the stage is idle.
    bus.wr_addr       = '0;
    bus.reg_wr_data   = '0;
    bus.reg_wr_data_2 = '0;
    bus.reg_wr_data_3 = '0;
    bus.reg_wr_data_4 = '0;
    if (out_valid) begin
      bus.wr_addr = addr_p1;
      if (dest_p1 == 2'd3) begin
        bus.reg_wr_data = {96'b0, data_p1[31:0]};
      end else begin
        bus.reg_wr_data   = data_p1[127:0];
        bus.reg_wr_data_2 = data_p1[255:128];
        bus.reg_wr_data_3 = data_p1[383:256];
        bus.reg_wr_data_4 = data_p1[511:384];
      end
    end
  end

  // ---- stage p1: captured write (data path, loaded only on transfer) -------
  always_ff @(posedge clk) begin
    if (transfer) begin
      dest_p1 <= dest_eff;
      addr_p1 <= win_addr;
      data_p1 <= win_data;
    end
  end

  // ---- stage p1: control registers -----------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_p1 <= 1'b0;
`ifdef CARRD_WB_RR_EN
      rr_ptr <= '0;
`endif
    end else begin
      err_p1 <= transfer && (dest_eff == 2'd0);
`ifdef CARRD_WB_RR_EN
      if (transfer)
        rr_ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
`endif
    end
  end

endmodule
